// File: rtl/count_monitor.sv
// Tracks a 4-bit up/down counter sampled on V and flags breaks in its sequence.
// Build option: COUNT_MONITOR_STICKY_EN makes FAULT absorbing until reset.
module count_monitor (
  input  logic       C,
  input  logic       R,
  input  logic       V,
  input  logic       M,
  input  logic [3:0] P,
  output logic       L,
  output logic       E,
  output logic       W,
  output logic [3:0] N
);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED, FAULT} state_t;

  state_t     state_reg, state_next;
  logic [3:0] prev_reg, prev_next;
  logic       mprev_reg, mprev_next;
  logic       e_reg, e_next;
  logic       w_reg, w_next;
  logic [3:0] n_reg, n_next;
  logic [3:0] exp_val;
  logic       wrap_step;

  always_comb begin
    exp_val   = M ? (prev_reg - 4'd1) : (prev_reg + 4'd1);
    wrap_step = M ? (prev_reg == 4'd0) : (prev_reg == 4'd15);
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_reg <= IDLE;
      prev_reg  <= 4'd0;
      mprev_reg <= 1'b0;
      e_reg     <= 1'b0;
      w_reg     <= 1'b0;
      n_reg     <= 4'd0;
    end else begin
      state_reg <= state_next;
      prev_reg  <= prev_next;
      mprev_reg <= mprev_next;
      e_reg     <= e_next;
      w_reg     <= w_next;
      n_reg     <= n_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    prev_next  = prev_reg;
    mprev_next = mprev_reg;
    n_next     = n_reg;
    e_next     = 1'b0;
    w_next     = 1'b0;
    if (V) begin
      case (state_reg)
        IDLE: begin
          prev_next  = P;
          mprev_next = M;
          state_next = ACQ;
        end
        ACQ: begin
          prev_next  = P;
          mprev_next = M;
          if (P == exp_val && M == mprev_reg)
            state_next = LOCKED;
        end
        LOCKED: begin
          prev_next  = P;
          mprev_next = M;
          // A direction flip restarts acquisition rather than counting as an error.
          if (M != mprev_reg) begin
            state_next = ACQ;
          end else if (P == exp_val) begin
            w_next = wrap_step;
          end else begin
            state_next = FAULT;
            e_next     = 1'b1;
            n_next     = (n_reg == 4'd15) ? n_reg : (n_reg + 4'd1);
          end
        end
        FAULT: begin
`ifdef COUNT_MONITOR_STICKY_EN
          state_next = FAULT;
`else
          prev_next  = P;
          mprev_next = M;
          state_next = ACQ;
`endif
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign L = (state_reg == LOCKED);
  assign E = e_reg;
  assign W = w_reg;
  assign N = n_reg;

endmodule

// File: tb/tb_count_monitor.sv
// Directed self-checking bench for count_monitor; observed word is {L,E,W,N}.
module tb_count_monitor;

  logic       C;
  logic       R;
  logic       V;
  logic       M;
  logic [3:0] P;
  logic       L;
  logic       E;
  logic       W;
  logic [3:0] N;

  int checks;
  int failures;

  count_monitor dut (
    .C(C), .R(R), .V(V), .M(M), .P(P),
    .L(L), .E(E), .W(W), .N(N)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic step(input logic v, input logic m, input logic [3:0] p);
    @(negedge C);
    R = 1'b0; V = v; M = m; P = p;
    @(posedge C);
    #1;
  endtask

  task automatic do_reset();
    @(negedge C);
    R = 1'b1; V = 1'b1; M = 1'b1; P = 4'($urandom_range(0, 15));
    @(posedge C);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    for (int i = 0; i < 2; i++) begin
      do_reset();
      obs = {L, E, W, N};
      checks++;
      if (obs !== 7'b0) begin
        failures++;
        $display("FAIL reset[%0d]: got %b want %b", i, obs, 7'b0);
      end
    end
  endtask

  task automatic test_acquire();
    logic [3:0] ps [4] = '{4'd3, 4'd4, 4'd5, 4'd6};
    logic [6:0] ex [4] = '{7'b000_0000, 7'b100_0000, 7'b100_0000, 7'b100_0000};
    logic [6:0] obs;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, ps[i]);
      obs = {L, E, W, N};
      checks++;
      if (obs !== ex[i]) begin
        failures++;
        $display("FAIL acquire p=%0d: got %b want %b", ps[i], obs, ex[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] ps [6] = '{4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1};
    logic [6:0] ex [6] = '{7'b100_0000, 7'b100_0000, 7'b100_0000,
                           7'b100_0000, 7'b101_0000, 7'b100_0000};
    logic [6:0] obs;
    do_reset();
    step(1'b1, 1'b0, 4'd10);
    step(1'b1, 1'b0, 4'd11);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, ps[i]);
      obs = {L, E, W, N};
      checks++;
      if (obs !== ex[i]) begin
        failures++;
        $display("FAIL wrap_up p=%0d: got %b want %b", ps[i], obs, ex[i]);
      end
    end
  endtask

  task automatic test_fault();
    logic [3:0] ps [4] = '{4'd9, 4'd10, 4'd11, 4'd12};
`ifdef COUNT_MONITOR_STICKY_EN
    logic [6:0] ex [4] = '{7'b010_0001, 7'b000_0001, 7'b000_0001, 7'b000_0001};
`else
    logic [6:0] ex [4] = '{7'b010_0001, 7'b000_0001, 7'b100_0001, 7'b100_0001};
`endif
    logic [6:0] obs;
    do_reset();
    step(1'b1, 1'b0, 4'd6);
    step(1'b1, 1'b0, 4'd7);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, ps[i]);
      obs = {L, E, W, N};
      checks++;
      if (obs !== ex[i]) begin
        failures++;
        $display("FAIL fault p=%0d: got %b want %b", ps[i], obs, ex[i]);
      end
    end
  endtask

  task automatic test_direction();
    logic       ms [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] ps [8] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd15, 4'd14};
    logic [6:0] ex [8] = '{7'b100_0000, 7'b000_0000, 7'b100_0000, 7'b100_0000,
                           7'b100_0000, 7'b100_0000, 7'b101_0000, 7'b100_0000};
    logic [6:0] obs;
    do_reset();
    step(1'b1, 1'b0, 4'd4);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, ms[i], ps[i]);
      obs = {L, E, W, N};
      checks++;
      if (obs !== ex[i]) begin
        failures++;
        $display("FAIL direction m=%0d p=%0d: got %b want %b", ms[i], ps[i], obs, ex[i]);
      end
    end
  endtask

  task automatic test_hold_and_stall();
    logic       vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       ms [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] ps [6] = '{4'd0, 4'd15, 4'd3, 4'd10, 4'd11, 4'd11};
    logic [6:0] ex [6] = '{7'b100_0000, 7'b100_0000, 7'b100_0000,
                           7'b100_0000, 7'b100_0000, 7'b010_0001};
    logic [6:0] obs;
    do_reset();
    step(1'b1, 1'b0, 4'd8);
    step(1'b1, 1'b0, 4'd9);
    for (int i = 0; i < 6; i++) begin
      step(vs[i], ms[i], ps[i]);
      obs = {L, E, W, N};
      checks++;
      if (obs !== ex[i]) begin
        failures++;
        $display("FAIL hold_stall[%0d] v=%0d p=%0d: got %b want %b", i, vs[i], ps[i], obs, ex[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [3:0] prev;
    logic [3:0] exp_n;
    logic [6:0] obs;
    logic [6:0] want;
    do_reset();
    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd1);
    prev  = 4'd1;
    exp_n = 4'd0;
`ifdef COUNT_MONITOR_STICKY_EN
    step(1'b1, 1'b0, prev + 4'd3);
    obs = {L, E, W, N};
    checks++;
    if (obs !== 7'b010_0001) begin
      failures++;
      $display("FAIL sticky_first_err: got %b want %b", obs, 7'b010_0001);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, k[0], 4'(k + 5));
      obs = {L, E, W, N};
      checks++;
      if (obs !== 7'b000_0001) begin
        failures++;
        $display("FAIL sticky_hold[%0d]: got %b want %b", k, obs, 7'b000_0001);
      end
    end
    do_reset();
`else
    for (int k = 1; k <= 17; k++) begin
      exp_n = (exp_n == 4'd15) ? exp_n : exp_n + 4'd1;
      prev  = prev + 4'd3;
      step(1'b1, 1'b0, prev);
      obs  = {L, E, W, N};
      want = {3'b010, exp_n};
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL sat_err[%0d]: got %b want %b", k, obs, want);
      end
      prev = prev + 4'd5;
      step(1'b1, 1'b0, prev);
      prev = prev + 4'd1;
      step(1'b1, 1'b0, prev);
      obs  = {L, E, W, N};
      want = {3'b100, exp_n};
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL sat_relock[%0d]: got %b want %b", k, obs, want);
      end
    end
    @(negedge C);
    R = 1'b1; V = 1'b1; M = 1'b0; P = prev + 4'd7;
    @(posedge C);
    #1;
`endif
    obs = {L, E, W, N};
    checks++;
    if (obs !== 7'b0) begin
      failures++;
      $display("FAIL sat_reset: got %b want %b", obs, 7'b0);
    end
    step(1'b1, 1'b0, 4'd5);
    obs = {L, E, W, N};
    checks++;
    if (obs !== 7'b0) begin
      failures++;
      $display("FAIL post_reset_idle: got %b want %b", obs, 7'b0);
    end
    step(1'b1, 1'b0, 4'd6);
    obs = {L, E, W, N};
    checks++;
    if (obs !== 7'b100_0000) begin
      failures++;
      $display("FAIL post_reset_lock: got %b want %b", obs, 7'b100_0000);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    R = 1'b1; V = 1'b0; M = 1'b0; P = 4'd0;
    test_reset();
    test_acquire();
    test_wrap();
    test_fault();
    test_direction();
    test_hold_and_stall();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
